// File: rtl/mod_segment_swapper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mod_segment_swapper_pkg
// Description : Modulation settings type, transition-mode codes, swap
//               controller state encoding and mode-validity helper.
//               Optional feature macro: MOD_EXT_MODE_EN (EXT mode 0xF0).
// Revision    : 1.0 - initial release
// ============================================================================
package mod_segment_swapper_pkg;

    // Width of the sampler index space carried in CYCLE
    localparam int MOD_DEPTH = 15;

    localparam logic [7:0]  TRANSITION_MODE_SYNC_IDX  = 8'h00;
    localparam logic [7:0]  TRANSITION_MODE_SYS_TIME  = 8'h01;
    localparam logic [7:0]  TRANSITION_MODE_GPIO      = 8'h02;
    localparam logic [7:0]  TRANSITION_MODE_EXT       = 8'hF0;
    localparam logic [7:0]  TRANSITION_MODE_IMMEDIATE = 8'hFF;

    // Repeat count meaning "play forever"
    localparam logic [15:0] REP_INFINITE = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PENDING = 2'd1,
        ST_FINITE  = 2'd2,
        ST_HOLD    = 2'd3
    } swap_state_t;

    typedef struct packed {
        logic                       UPDATE;
        logic                       REQ_RD_SEGMENT;
        logic [7:0]                 TRANSITION_MODE;
        logic [63:0]                TRANSITION_VALUE;
        logic [1:0][15:0]           REP;
        logic [1:0][MOD_DEPTH-1:0]  CYCLE;
    } mod_settings_t;

    // True for transition codes this build understands; others are dropped
    function automatic logic is_valid_mode(input logic [7:0] mode);
        case (mode)
            TRANSITION_MODE_SYNC_IDX,
            TRANSITION_MODE_SYS_TIME,
            TRANSITION_MODE_GPIO,
            TRANSITION_MODE_IMMEDIATE: return 1'b1;
`ifdef MOD_EXT_MODE_EN
            TRANSITION_MODE_EXT:       return 1'b1;
`endif
            default:                   return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mod_segment_swapper_gpio_sync.sv
`default_nettype none
// ============================================================================
// Module      : gpio_edge_sync
// Description : Two-flop synchroniser for asynchronous trigger pins with a
//               registered per-bit rising-edge pulse. Async active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_edge_sync
    import mod_segment_swapper_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_sync_d;
    logic [WIDTH-1:0] r_rise;

    // Resolve metastability, keep previous level and register the edge pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta   <= '0;
            r_sync   <= '0;
            r_sync_d <= '0;
            r_rise   <= '0;
        end else begin
            r_meta   <= i_async;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
            r_rise   <= r_sync & ~r_sync_d;
        end
    end

    assign o_rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/mod_segment_swapper.sv
`default_nettype none
// ============================================================================
// Module      : mod_segment_swapper
// Description : Modulation segment swap controller. Latches segment requests,
//               waits for the requested trigger, swaps the sampler's segment
//               and stops it after a finite repeat count.
//               Optional feature macro: MOD_EXT_MODE_EN (auto-alternating EXT).
// Revision    : 1.0 - initial release
// ============================================================================
module mod_segment_swapper
    import mod_segment_swapper_pkg::*;
#(
    parameter int DEPTH = 15
) (
    input  logic          CLK,
    input  logic          RST,
    input  mod_settings_t MOD_SETTINGS,
    input  logic [63:0]   SYS_TIME,
    input  logic          LOOP_END,
    input  logic [3:0]    GPIO_IN,
    output logic          SEGMENT,
    output logic          STOP,
    output logic          SWAP,
    output logic [15:0]   LOOP_CNT
);

    swap_state_t r_state;
    swap_state_t w_state_next;

    logic        r_segment;
    logic        r_stop;
    logic        r_swap;
    logic [15:0] r_loop_cnt;
    logic        w_segment_next;
    logic        w_stop_next;
    logic        w_swap_next;
    logic [15:0] w_loop_cnt_next;

    // Pending request; also governs the FINITE run it launches
    logic        r_req_segment;
    logic [7:0]  r_req_mode;
    logic [63:0] r_req_value;
    logic [15:0] r_req_rep;
    logic        r_time_ge;

    logic [3:0]  w_gpio_rise;
    logic        w_update_ok;
    logic        w_trigger_cond;
    logic        w_trigger;
    logic        w_loop_evt;
    logic        w_loop_last;
    logic        w_ext_active;

    // The sampler owns the index space; CYCLE is only passed through here
    logic [DEPTH-1:0] w_unused_cycle;
    logic             w_unused;
    assign w_unused_cycle = MOD_SETTINGS.CYCLE[r_segment];
    assign w_unused       = ^{w_unused_cycle, MOD_SETTINGS.CYCLE};

    gpio_edge_sync #(
        .WIDTH (4)
    ) u_gpio_sync (
        .clk     (CLK),
        .rst     (RST),
        .i_async (GPIO_IN),
        .o_rise  (w_gpio_rise)
    );

    // Unknown transition codes are dropped entirely: no latch, no state change
    assign w_update_ok = MOD_SETTINGS.UPDATE && is_valid_mode(MOD_SETTINGS.TRANSITION_MODE);

`ifdef MOD_EXT_MODE_EN
    assign w_ext_active = (r_req_mode == TRANSITION_MODE_EXT);
`else
    assign w_ext_active = 1'b0;
`endif

    // Trigger condition of the pending request; a stopped sampler never emits
    // LOOP_END, so index-synchronous requests fire at once while stopped
    always_comb begin
        w_trigger_cond = 1'b0;
        case (r_req_mode)
            TRANSITION_MODE_SYNC_IDX:  w_trigger_cond = LOOP_END | r_stop;
            TRANSITION_MODE_SYS_TIME:  w_trigger_cond = r_time_ge;
            TRANSITION_MODE_GPIO:      w_trigger_cond = w_gpio_rise[r_req_value[1:0]];
            TRANSITION_MODE_IMMEDIATE: w_trigger_cond = 1'b1;
`ifdef MOD_EXT_MODE_EN
            TRANSITION_MODE_EXT:       w_trigger_cond = LOOP_END | r_stop;
`endif
            default:                   w_trigger_cond = 1'b0;
        endcase
    end

    // A fresh valid UPDATE overrides both a pending trigger and a loop count
    assign w_trigger   = (r_state == ST_PENDING) && !w_update_ok && w_trigger_cond;
    assign w_loop_evt  = (r_state == ST_FINITE) && LOOP_END && !w_update_ok;
    assign w_loop_last = w_loop_evt && (r_loop_cnt == r_req_rep);

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        if (w_update_ok) begin
            w_state_next = ST_PENDING;
        end else if (w_trigger) begin
            w_state_next = (r_req_rep == REP_INFINITE) ? ST_RUN : ST_FINITE;
        end else if (w_loop_last && !w_ext_active) begin
            w_state_next = ST_HOLD;
        end
    end

    // Output next values: swap on trigger, count loops, stop or alternate at end
    always_comb begin
        w_segment_next  = r_segment;
        w_stop_next     = r_stop;
        w_swap_next     = 1'b0;
        w_loop_cnt_next = r_loop_cnt;
        if (w_trigger) begin
            w_segment_next  = r_req_segment;
            w_stop_next     = 1'b0;
            w_swap_next     = 1'b1;
            w_loop_cnt_next = '0;
        end else if (w_loop_evt) begin
            w_loop_cnt_next = r_loop_cnt + 16'd1;
            if (w_loop_last) begin
                w_swap_next = 1'b1;
                if (w_ext_active) begin
                    w_segment_next  = ~r_segment;
                    w_loop_cnt_next = '0;
                end else begin
                    w_stop_next = 1'b1;
                end
            end
        end
    end

    // Output registers, request latch and registered time comparison
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_segment     <= 1'b0;
            r_stop        <= 1'b0;
            r_swap        <= 1'b0;
            r_loop_cnt    <= '0;
            r_req_segment <= 1'b0;
            r_req_mode    <= TRANSITION_MODE_SYNC_IDX;
            r_req_value   <= '0;
            r_req_rep     <= '0;
            r_time_ge     <= 1'b0;
        end else begin
            r_segment  <= w_segment_next;
            r_stop     <= w_stop_next;
            r_swap     <= w_swap_next;
            r_loop_cnt <= w_loop_cnt_next;
            if (w_update_ok) begin
                r_req_segment <= MOD_SETTINGS.REQ_RD_SEGMENT;
                r_req_mode    <= MOD_SETTINGS.TRANSITION_MODE;
                r_req_value   <= MOD_SETTINGS.TRANSITION_VALUE;
                r_req_rep     <= MOD_SETTINGS.REP[MOD_SETTINGS.REQ_RD_SEGMENT];
            end
            // Compare against the incoming value on UPDATE so a time already
            // in the past fires in the first pending cycle
            r_time_ge <= w_update_ok ? (SYS_TIME >= MOD_SETTINGS.TRANSITION_VALUE)
                                     : (SYS_TIME >= r_req_value);
        end
    end

    assign SEGMENT  = r_segment;
    assign STOP     = r_stop;
    assign SWAP     = r_swap;
    assign LOOP_CNT = r_loop_cnt;

endmodule
`default_nettype wire
